posit_decode_arbiter: RTL and testbench



---
 rtl/posit_decode_arbiter.sv | 174 +++++++++++++++++
 tb/tb_posit_decode_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/posit_decode_arbiter.sv
// Round-robin arbiter sharing one pipelined posit decoder between requesters.
// Tags ride a tracker alongside the decoder and results land in per-requester slots.
module posit_decode_arbiter #(
    parameter int N_REQ   = 4,
    parameter int IN_S    = 8,
    parameter int EXP_S   = 2,
    parameter int DEC_LAT = 3,
    localparam int REG_S  = $clog2(IN_S) + 1,
    localparam int MTS_S  = IN_S - 3 - EXP_S,
    localparam int TAG_W  = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req_vld_i,
    output logic [N_REQ-1:0]       req_rdy_o,
    input  logic [N_REQ*IN_S-1:0]  req_data_i,
    output logic [N_REQ-1:0]       rsp_vld_o,
    input  logic [N_REQ-1:0]       rsp_rdy_i,
    output logic [N_REQ-1:0]       rsp_sign_o,
    output logic [N_REQ*REG_S-1:0] rsp_regi_o,
    output logic [N_REQ*EXP_S-1:0] rsp_exp_o,
    output logic [N_REQ*MTS_S-1:0] rsp_mts_o,
    output logic [N_REQ*2-1:0]     rsp_type_o,
    output logic [IN_S-1:0]        dec_in_o,
    output logic                   dec_vld_o,
    input  logic                   dec_sign_i,
    input  logic [REG_S-1:0]       dec_regi_i,
    input  logic [EXP_S-1:0]       dec_exp_i,
    input  logic [MTS_S-1:0]       dec_mts_i,
    input  logic [1:0]             dec_type_i,
    output logic                   busy_o
);

    logic [TAG_W-1:0]         ptr_q, ptr_d;
    logic [N_REQ-1:0]         busy_q, busy_d;
    logic                     dec_vld_q, dec_vld_d;
    logic [IN_S-1:0]          dec_in_q, dec_in_d;
    logic [TAG_W-1:0]         dec_tag_q, dec_tag_d;
    logic [DEC_LAT-1:0]       trk_vld_q, trk_vld_d;
    logic [DEC_LAT-1:0][TAG_W-1:0] trk_tag_q, trk_tag_d;
    logic [N_REQ-1:0]         rsp_vld_q, rsp_vld_d;
    logic [N_REQ-1:0]         rsp_sign_q, rsp_sign_d;
    logic [N_REQ*REG_S-1:0]   rsp_regi_q, rsp_regi_d;
    logic [N_REQ*EXP_S-1:0]   rsp_exp_q, rsp_exp_d;
    logic [N_REQ*MTS_S-1:0]   rsp_mts_q, rsp_mts_d;
    logic [N_REQ*2-1:0]       rsp_type_q, rsp_type_d;

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] hs;
    logic             gnt_found;
    logic [TAG_W-1:0] gnt_tag;
    logic             cap_vld;
    logic [TAG_W-1:0] cap_tag;
    int               idx;

    // Grants are masked during reset so every output reads zero immediately.
    always_comb begin
        eligible  = req_vld_i & ~busy_q & {N_REQ{rstn}};
        gnt_found = 1'b0;
        gnt_tag   = '0;
        idx       = 0;
        req_rdy_o = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!gnt_found && eligible[idx]) begin
                gnt_found = 1'b1;
                gnt_tag   = TAG_W'(idx);
            end
        end
        if (gnt_found) req_rdy_o[gnt_tag] = 1'b1;
    end

    always_comb begin
        ptr_d     = ptr_q;
        dec_vld_d = gnt_found;
        dec_in_d  = dec_in_q;
        dec_tag_d = dec_tag_q;
        if (gnt_found) begin
            ptr_d     = (int'(gnt_tag) == N_REQ - 1) ? '0 : gnt_tag + TAG_W'(1);
            dec_in_d  = req_data_i[gnt_tag*IN_S +: IN_S];
            dec_tag_d = gnt_tag;
        end
    end

    always_comb begin
        trk_vld_d = trk_vld_q;
        trk_tag_d = trk_tag_q;
        for (int i = 0; i < DEC_LAT; i++) begin
            if (i == 0) begin
                trk_vld_d[0] = dec_vld_q;
                trk_tag_d[0] = dec_tag_q;
            end else begin
                trk_vld_d[i] = trk_vld_q[i-1];
                trk_tag_d[i] = trk_tag_q[i-1];
            end
        end
    end

    assign cap_vld = trk_vld_q[DEC_LAT-1];
    assign cap_tag = trk_tag_q[DEC_LAT-1];
    assign hs      = rsp_vld_q & rsp_rdy_i;

    // Capture and handshake never hit the same slot in one cycle.
    always_comb begin
        busy_d     = (busy_q | req_rdy_o) & ~hs;
        rsp_vld_d  = rsp_vld_q;
        rsp_sign_d = rsp_sign_q;
        rsp_regi_d = rsp_regi_q;
        rsp_exp_d  = rsp_exp_q;
        rsp_mts_d  = rsp_mts_q;
        rsp_type_d = rsp_type_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (cap_vld && cap_tag == TAG_W'(k)) begin
                rsp_vld_d[k]               = 1'b1;
                rsp_sign_d[k]              = dec_sign_i;
                rsp_regi_d[k*REG_S +: REG_S] = dec_regi_i;
                rsp_exp_d[k*EXP_S +: EXP_S]  = dec_exp_i;
                rsp_mts_d[k*MTS_S +: MTS_S]  = dec_mts_i;
                rsp_type_d[k*2 +: 2]         = dec_type_i;
            end else if (hs[k]) begin
                rsp_vld_d[k]               = 1'b0;
                rsp_sign_d[k]              = 1'b0;
                rsp_regi_d[k*REG_S +: REG_S] = '0;
                rsp_exp_d[k*EXP_S +: EXP_S]  = '0;
                rsp_mts_d[k*MTS_S +: MTS_S]  = '0;
                rsp_type_d[k*2 +: 2]         = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            ptr_q      <= '0;
            busy_q     <= '0;
            dec_vld_q  <= 1'b0;
            dec_in_q   <= '0;
            dec_tag_q  <= '0;
            trk_vld_q  <= '0;
            trk_tag_q  <= '0;
            rsp_vld_q  <= '0;
            rsp_sign_q <= '0;
            rsp_regi_q <= '0;
            rsp_exp_q  <= '0;
            rsp_mts_q  <= '0;
            rsp_type_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            busy_q     <= busy_d;
            dec_vld_q  <= dec_vld_d;
            dec_in_q   <= dec_in_d;
            dec_tag_q  <= dec_tag_d;
            trk_vld_q  <= trk_vld_d;
            trk_tag_q  <= trk_tag_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_sign_q <= rsp_sign_d;
            rsp_regi_q <= rsp_regi_d;
            rsp_exp_q  <= rsp_exp_d;
            rsp_mts_q  <= rsp_mts_d;
            rsp_type_q <= rsp_type_d;
        end
    end

    assign dec_vld_o  = dec_vld_q;
    assign dec_in_o   = dec_in_q;
    assign rsp_vld_o  = rsp_vld_q;
    assign rsp_sign_o = rsp_sign_q;
    assign rsp_regi_o = rsp_regi_q;
    assign rsp_exp_o  = rsp_exp_q;
    assign rsp_mts_o  = rsp_mts_q;
    assign rsp_type_o = rsp_type_q;
    assign busy_o     = |busy_q;

endmodule

// File: tb/tb_posit_decode_arbiter.sv
// Bench for posit_decode_arbiter: behavioural decoder, arbitration model,
// per-requester scoreboard of decoded fields and response timing.
module tb_posit_decode_arbiter;

    localparam int N = 4;
    localparam int W = 8;
    localparam int DL = 3;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req_vld = '0;
    logic [N-1:0]    req_rdy_o;
    logic [N*W-1:0]  req_data = '0;
    logic [N-1:0]    rsp_vld_o;
    logic [N-1:0]    rsp_rdy = '1;
    logic [N-1:0]    rsp_sign_o;
    logic [N*4-1:0]  rsp_regi_o;
    logic [N*2-1:0]  rsp_exp_o;
    logic [N*3-1:0]  rsp_mts_o;
    logic [N*2-1:0]  rsp_type_o;
    logic [W-1:0]    dec_in_o;
    logic            dec_vld_o;
    logic [11:0]     dp [DL];
    logic            busy_o;

    always #5 clk = ~clk;

    posit_decode_arbiter dut (
        .clk_i(clk), .rstn(rstn),
        .req_vld_i(req_vld), .req_rdy_o(req_rdy_o), .req_data_i(req_data),
        .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy),
        .rsp_sign_o(rsp_sign_o), .rsp_regi_o(rsp_regi_o),
        .rsp_exp_o(rsp_exp_o), .rsp_mts_o(rsp_mts_o), .rsp_type_o(rsp_type_o),
        .dec_in_o(dec_in_o), .dec_vld_o(dec_vld_o),
        .dec_sign_i(dp[DL-1][11]), .dec_regi_i(dp[DL-1][10:7]),
        .dec_exp_i(dp[DL-1][6:5]), .dec_mts_i(dp[DL-1][4:2]),
        .dec_type_i(dp[DL-1][1:0]),
        .busy_o(busy_o)
    );

    // Packed result: {sign, regime[3:0], exp[1:0], mts[2:0], type[1:0]}
    function automatic logic [11:0] pdec(logic [7:0] x);
        logic s; logic [7:0] v; logic [6:0] rem, tail;
        logic [1:0] t; logic [3:0] rg; int run, k; bit stop;
        s = x[7]; rg = '0; tail = '0; t = 2'b01;
        if (x == 8'h00) t = 2'b00;
        else if (x == 8'h80) t = 2'b10;
        else begin
            v = s ? -x : x;
            rem = v[6:0];
            run = 0; stop = 0;
            for (int i = 6; i >= 0; i--) begin
                if (!stop && rem[i] == rem[6]) run++;
                else stop = 1;
            end
            k = rem[6] ? run - 1 : -run;
            rg = 4'(k);
            tail = (run + 1 >= 7) ? 7'd0 : rem << (run + 1);
        end
        return {s, rg, tail[6:5], tail[4:2], t};
    endfunction

    always @(posedge clk) begin
        dp[0] <= pdec(dec_in_o);
        for (int i = 1; i < DL; i++) dp[i] <= dp[i-1];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct { logic [11:0] f; int due; } sb_t;
    sb_t      sb [N][$];
    bit       seen [N];
    logic [N-1:0] mbusy = '0;
    int       mptr = 0;
    bit       pv = 0;
    logic [W-1:0] pdata = '0;
    logic [N-1:0] hs_vec = '0;
    int       cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [N-1:0] elig, eg;
        logic [11:0] obs;
        int g, ix;
        if (!rstn) begin
            for (int k = 0; k < N; k++) begin sb[k].delete(); seen[k] = 0; end
            mbusy = '0; mptr = 0; pv = 0; hs_vec = '0;
        end else begin
            elig = req_vld & ~mbusy;
            eg = '0; g = -1;
            for (int i = 0; i < N; i++) begin
                ix = (mptr + i) % N;
                if (g < 0 && elig[ix]) g = ix;
            end
            if (g >= 0) eg[g] = 1'b1;
            check("grant", 32'(req_rdy_o), 32'(eg));
            check("dec_vld", 32'(dec_vld_o), 32'(pv));
            if (pv) check("dec_in", 32'(dec_in_o), 32'(pdata));
            check("busy", 32'(busy_o), 32'(|mbusy));
            for (int k = 0; k < N; k++) begin
                if (sb[k].size() > 0) begin
                    if (!seen[k])
                        check($sformatf("rsp_vld%0d", k), 32'(rsp_vld_o[k]),
                              32'(cyc >= sb[k][0].due));
                    else
                        check($sformatf("hold%0d", k), 32'(rsp_vld_o[k]), 32'd1);
                    if (rsp_vld_o[k]) begin
                        seen[k] = 1;
                        obs = {rsp_sign_o[k], rsp_regi_o[k*4 +: 4],
                               rsp_exp_o[k*2 +: 2], rsp_mts_o[k*3 +: 3],
                               rsp_type_o[k*2 +: 2]};
                        check($sformatf("fields%0d", k), 32'(obs), 32'(sb[k][0].f));
                        if (rsp_rdy[k]) begin
                            void'(sb[k].pop_front());
                            seen[k] = 0;
                            mbusy[k] = 1'b0;
                        end
                    end
                end else begin
                    check($sformatf("spurious%0d", k), 32'(rsp_vld_o[k]), 32'd0);
                end
            end
            pv = (g >= 0);
            if (g >= 0) begin
                pdata = req_data[g*W +: W];
                sb[g].push_back('{f: pdec(pdata), due: cyc + DL + 2});
                mbusy[g] = 1'b1;
                mptr = (g + 1) % N;
            end
            hs_vec = eg;
        end
    end

    logic [W-1:0] dq [N][$];

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            req_vld[k] = dq[k].size() > 0;
            req_data[k*W +: W] = (dq[k].size() > 0) ? dq[k][0] : '0;
        end
    endtask

    task automatic tick(int n = 1);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            if (rstn)
                for (int k = 0; k < N; k++)
                    if (hs_vec[k]) void'(dq[k].pop_front());
            drive();
        end
    endtask

    task automatic check_zero(string tag);
        check({tag, "_rdy"}, 32'(req_rdy_o), 0);
        check({tag, "_rsp_vld"}, 32'(rsp_vld_o), 0);
        check({tag, "_dec_vld"}, 32'(dec_vld_o), 0);
        check({tag, "_dec_in"}, 32'(dec_in_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_fields"}, 32'({rsp_sign_o, rsp_regi_o, rsp_exp_o}), 0);
        check({tag, "_fields2"}, 32'({rsp_mts_o, rsp_type_o}), 0);
    endtask

    initial begin
        int left;
        repeat (2) @(posedge clk);
        #1 check_zero("reset");
        rstn = 1'b1;
        tick(2);

        dq[0].push_back(8'h40); drive();
        tick(10);

        dq[2].push_back(8'h00); dq[2].push_back(8'h80); drive();
        tick(16);

        dq[3].push_back(8'h3c); drive();
        tick(10);
        for (int k = 0; k < N; k++) dq[k].push_back(8'($urandom_range(1, 255)));
        drive();
        tick(14);

        rsp_rdy[1] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            dq[0].push_back(8'($urandom)); dq[1].push_back(8'($urandom));
            dq[2].push_back(8'($urandom));
        end
        drive();
        tick(24);
        rsp_rdy[1] = 1'b1;
        tick(30);

        for (int j = 0; j < 8; j++) dq[0].push_back(8'($urandom));
        drive();
        tick(3);
        dq[3].push_back(8'hc8); dq[3].push_back(8'h7f); drive();
        tick(60);

        rsp_rdy = 4'b0110;
        tick(4);
        rsp_rdy = '1;
        tick(10);

        for (int k = 0; k < 3; k++) dq[k].push_back(8'h55 + 8'(k));
        drive();
        tick(3);
        rstn = 1'b0;
        #1 check_zero("mid_reset");
        for (int k = 0; k < N; k++) dq[k].delete();
        drive();
        tick(2);
        rstn = 1'b1;
        tick(12);

        left = 0;
        for (int k = 0; k < N; k++) left += sb[k].size();
        check("drain", 32'(left), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
